// File: rtl/load_queue_unit.sv
// load_queue_unit: load queue with store-buffer forwarding, in-order issue and retire,
// and out-of-order memory responses matched by tag.
module load_queue_unit #(
  parameter int DEPTH = 4,
  parameter logic [31:0] PRIV_START = 32'hFFFF_0000,
  parameter logic [31:0] PRIV_END = 32'hFFFF_FFFF,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             privilege_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      address_i,
  input  logic [1:0]       uop_i,
  input  logic             signed_i,
  input  logic             fwd_match_i,
  input  logic [31:0]      fwd_data_i,
  input  logic             buffer_empty_i,
  output logic             req_o,
  input  logic             req_ready_i,
  output logic [31:0]      req_addr_o,
  output logic [TAG_W-1:0] req_tag_o,
  input  logic             rsp_valid_i,
  input  logic [TAG_W-1:0] rsp_tag_i,
  input  logic [31:0]      rsp_data_i,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic [31:0]      data_o,
  output logic             misaligned_o,
  output logic             illegal_access_o,
  output logic             idle_o
);
  typedef enum logic [2:0] {S_FREE, S_WAIT, S_PEND, S_FLY, S_DONE} state_t;
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);
  state_t st [DEPTH];
  state_t st_n [DEPTH];
  logic [1:0] uop [DEPTH];
  logic [1:0] uop_n [DEPTH];
  logic [1:0] off [DEPTH];
  logic [1:0] off_n [DEPTH];
  logic sgn [DEPTH];
  logic sgn_n [DEPTH];
  logic mis [DEPTH];
  logic mis_n [DEPTH];
  logic ill [DEPTH];
  logic ill_n [DEPTH];
  logic [31:0] dat [DEPTH];
  logic [31:0] dat_n [DEPTH];
  logic [TAG_W-1:0] alloc, iss, ret, alloc_n, iss_n, ret_n;
  logic [TAG_W:0] count, count_n, pend, pend_n;
  logic acc, iss_go, ret_go, bad_mis, bad_ill;

  function automatic logic [31:0] slice(input logic [31:0] d, input logic [1:0] u, input logic s, input logic [1:0] o);
    logic [7:0] b;
    logic [15:0] h;
    b = d[{o, 3'b000} +: 8];
    h = o[1] ? d[31:16] : d[15:0];
    return u[1] ? d : u[0] ? {{16{s & h[15]}}, h} : {{24{s & b[7]}}, b};
  endfunction

  assign ready_o = count != FULL;
  assign idle_o = count == '0;

  // Pending entries keep their word address in the data field until the response overwrites it.
  always_comb begin
    acc = valid_i & ready_o;
    ret_go = data_valid_o & data_ready_i;
    iss_go = (req_o & req_ready_i) | (pend != '0 && st[iss] == S_DONE);
    bad_mis = uop_i[1] ? address_i[1:0] != 2'b00 : uop_i[0] & address_i[0];
    bad_ill = !privilege_i && {1'b0, address_i} >= {1'b0, PRIV_START} && {1'b0, address_i} <= {1'b0, PRIV_END};
    st_n = st;
    uop_n = uop;
    off_n = off;
    sgn_n = sgn;
    mis_n = mis;
    ill_n = ill;
    dat_n = dat;
    for (int i = 0; i < DEPTH; i++)
      if (st[i] == S_WAIT && buffer_empty_i) st_n[i] = S_PEND;
    if (req_o & req_ready_i) st_n[iss] = S_FLY;
    if (rsp_valid_i && st[rsp_tag_i] == S_FLY) begin
      st_n[rsp_tag_i] = S_DONE;
      dat_n[rsp_tag_i] = rsp_data_i;
    end
    if (ret_go) st_n[ret] = S_FREE;
    if (acc) begin
      st_n[alloc] = (bad_mis | bad_ill | fwd_match_i) ? S_DONE : uop_i[1] ? S_PEND : S_WAIT;
      dat_n[alloc] = (bad_mis | bad_ill) ? '0 : fwd_match_i ? fwd_data_i : {address_i[31:2], 2'b00};
      uop_n[alloc] = uop_i;
      off_n[alloc] = address_i[1:0];
      sgn_n[alloc] = signed_i;
      mis_n[alloc] = bad_mis;
      ill_n[alloc] = bad_ill;
    end
    alloc_n = alloc + TAG_W'(acc);
    iss_n = iss + TAG_W'(iss_go);
    ret_n = ret + TAG_W'(ret_go);
    count_n = count + (TAG_W+1)'(acc) - (TAG_W+1)'(ret_go);
    pend_n = pend + (TAG_W+1)'(acc) - (TAG_W+1)'(iss_go);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= S_FREE;
      alloc <= '0;
      iss <= '0;
      ret <= '0;
      count <= '0;
      pend <= '0;
      req_o <= 1'b0;
      req_addr_o <= '0;
      req_tag_o <= '0;
      data_valid_o <= 1'b0;
      data_o <= '0;
      misaligned_o <= 1'b0;
      illegal_access_o <= 1'b0;
    end else begin
      st <= st_n;
      uop <= uop_n;
      off <= off_n;
      sgn <= sgn_n;
      mis <= mis_n;
      ill <= ill_n;
      dat <= dat_n;
      alloc <= alloc_n;
      iss <= iss_n;
      ret <= ret_n;
      count <= count_n;
      pend <= pend_n;
      req_o <= pend_n != '0 && st_n[iss_n] == S_PEND;
      req_addr_o <= dat_n[iss_n];
      req_tag_o <= iss_n;
      data_valid_o <= st_n[ret_n] == S_DONE;
      data_o <= slice(dat_n[ret_n], uop_n[ret_n], sgn_n[ret_n], off_n[ret_n]);
      misaligned_o <= mis_n[ret_n];
      illegal_access_o <= ill_n[ret_n];
    end
  end
endmodule

// File: tb/tb_load_queue_unit.sv
// tb_load_queue_unit: directed scenario tasks with hand-computed expectations.
module tb_load_queue_unit;
  logic clk_i = 0, rst_i = 1, privilege_i = 1, valid_i = 0, signed_i = 0, fwd_match_i = 0;
  logic buffer_empty_i = 1, req_ready_i = 1, rsp_valid_i = 0, data_ready_i = 0;
  logic [31:0] address_i = 0, fwd_data_i = 0, rsp_data_i = 0;
  logic [1:0] uop_i = 0, rsp_tag_i = 0;
  logic ready_o, req_o, data_valid_o, misaligned_o, illegal_access_o, idle_o;
  logic [31:0] req_addr_o, data_o;
  logic [1:0] req_tag_o;
  int checks = 0, failures = 0;

  load_queue_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .privilege_i(privilege_i), .valid_i(valid_i), .ready_o(ready_o),
    .address_i(address_i), .uop_i(uop_i), .signed_i(signed_i), .fwd_match_i(fwd_match_i),
    .fwd_data_i(fwd_data_i), .buffer_empty_i(buffer_empty_i), .req_o(req_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_tag_o(req_tag_o), .rsp_valid_i(rsp_valid_i), .rsp_tag_i(rsp_tag_i),
    .rsp_data_i(rsp_data_i), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
    .misaligned_o(misaligned_o), .illegal_access_o(illegal_access_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic load(input logic [31:0] a, input logic [1:0] u, input logic s, input logic p, input logic fm, input logic [31:0] fd);
    address_i = a; uop_i = u; signed_i = s; privilege_i = p; fwd_match_i = fm; fwd_data_i = fd; valid_i = 1;
    @(negedge clk_i);
    valid_i = 0; fwd_match_i = 0; privilege_i = 1;
  endtask

  task automatic respond(input logic [1:0] t, input logic [31:0] d);
    rsp_valid_i = 1; rsp_tag_i = t; rsp_data_i = d;
    @(negedge clk_i);
    rsp_valid_i = 0;
  endtask

  task automatic retire;
    data_ready_i = 1;
    @(negedge clk_i);
    data_ready_i = 0;
  endtask

  task automatic test_reset;
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
    checks++; if (idle_o !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle_o); end
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", req_o); end
    checks++; if (data_valid_o !== 1'b0) begin failures++; $display("FAIL rst_dv got=%b exp=0", data_valid_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", data_o); end
    checks++; if ({misaligned_o, illegal_access_o} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", misaligned_o, illegal_access_o); end
    rst_i = 0;
  endtask

  task automatic test_ldb_signed;
    load(32'h1003, 2'b00, 1, 1, 0, 0);
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL ldb_req_wait got=%b exp=0", req_o); end
    @(negedge clk_i);
    checks++; if (req_o !== 1'b1) begin failures++; $display("FAIL ldb_req got=%b exp=1", req_o); end
    checks++; if (req_addr_o !== 32'h1000) begin failures++; $display("FAIL ldb_addr got=%h exp=00001000", req_addr_o); end
    checks++; if (req_tag_o !== 2'd0) begin failures++; $display("FAIL ldb_tag got=%0d exp=0", req_tag_o); end
    @(negedge clk_i);
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL ldb_req_drop got=%b exp=0", req_o); end
    respond(2'd0, 32'h80FF_FF12);
    checks++; if (data_valid_o !== 1'b1) begin failures++; $display("FAIL ldb_dv got=%b exp=1", data_valid_o); end
    checks++; if (data_o !== 32'hFFFF_FF80) begin failures++; $display("FAIL ldb_data got=%h exp=ffffff80", data_o); end
    @(negedge clk_i);
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'hFFFF_FF80) begin failures++; $display("FAIL ldb_hold dv=%b data=%h exp dv=1 data=ffffff80", data_valid_o, data_o); end
    retire();
    checks++; if (data_valid_o !== 1'b0 || idle_o !== 1'b1) begin failures++; $display("FAIL ldb_retire dv=%b idle=%b exp dv=0 idle=1", data_valid_o, idle_o); end
  endtask

  task automatic test_misaligned;
    load(32'h2002, 2'b10, 0, 1, 0, 0);
    checks++; if (data_valid_o !== 1'b1) begin failures++; $display("FAIL mis_dv got=%b exp=1", data_valid_o); end
    checks++; if ({misaligned_o, illegal_access_o} !== 2'b10) begin failures++; $display("FAIL mis_flags got=%b%b exp=10", misaligned_o, illegal_access_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL mis_data got=%h exp=0", data_o); end
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", req_o); end
    retire();
    checks++; if (req_o !== 1'b0 || idle_o !== 1'b1) begin failures++; $display("FAIL mis_after req=%b idle=%b exp req=0 idle=1", req_o, idle_o); end
  endtask

  task automatic test_illegal;
    load(32'hFFFF_0010, 2'b10, 0, 0, 0, 0);
    checks++; if (data_valid_o !== 1'b1 || illegal_access_o !== 1'b1 || misaligned_o !== 1'b0) begin failures++; $display("FAIL ill_flags dv=%b ill=%b mis=%b exp 1 1 0", data_valid_o, illegal_access_o, misaligned_o); end
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL ill_req got=%b exp=0", req_o); end
    retire();
    req_ready_i = 0;
    load(32'hFFFF_0010, 2'b10, 0, 1, 0, 0);
    checks++; if (req_o !== 1'b1 || req_addr_o !== 32'hFFFF_0010 || req_tag_o !== 2'd3) begin failures++; $display("FAIL mach_req req=%b addr=%h tag=%0d exp 1 ffff0010 3", req_o, req_addr_o, req_tag_o); end
    @(negedge clk_i);
    checks++; if (req_o !== 1'b1 || req_addr_o !== 32'hFFFF_0010 || req_tag_o !== 2'd3) begin failures++; $display("FAIL mach_stable req=%b addr=%h tag=%0d exp 1 ffff0010 3", req_o, req_addr_o, req_tag_o); end
    req_ready_i = 1;
    @(negedge clk_i);
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL mach_req_drop got=%b exp=0", req_o); end
    respond(2'd3, 32'h1234_5678);
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'h1234_5678 || illegal_access_o !== 1'b0) begin failures++; $display("FAIL mach_data dv=%b data=%h ill=%b exp 1 12345678 0", data_valid_o, data_o, illegal_access_o); end
    retire();
  endtask

  task automatic test_out_of_order;
    for (int i = 0; i < 4; i++) begin
      address_i = 32'h4000 + 32'(4 * i); uop_i = 2'b10; signed_i = 0; valid_i = 1;
      @(negedge clk_i);
      checks++; if (req_o !== 1'b1 || req_tag_o !== 2'(i)) begin failures++; $display("FAIL ooo_issue%0d req=%b tag=%0d exp req=1 tag=%0d", i, req_o, req_tag_o, i); end
    end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL ooo_full got=%b exp=0", ready_o); end
    valid_i = 0;
    @(negedge clk_i);
    for (int i = 3; i > 0; i--) respond(2'(i), 32'hC0DE_0000 + 32'(i));
    checks++; if (data_valid_o !== 1'b0) begin failures++; $display("FAIL ooo_blocked got=%b exp=0", data_valid_o); end
    respond(2'd0, 32'hC0DE_0000);
    data_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_valid_o !== 1'b1 || data_o !== 32'hC0DE_0000 + 32'(i)) begin failures++; $display("FAIL ooo_retire%0d dv=%b data=%h exp dv=1 data=%h", i, data_valid_o, data_o, 32'hC0DE_0000 + 32'(i)); end
      @(negedge clk_i);
    end
    data_ready_i = 0;
    checks++; if (data_valid_o !== 1'b0 || idle_o !== 1'b1 || ready_o !== 1'b1) begin failures++; $display("FAIL ooo_drained dv=%b idle=%b ready=%b exp 0 1 1", data_valid_o, idle_o, ready_o); end
  endtask

  task automatic test_ldh_drain;
    buffer_empty_i = 0;
    load(32'h3002, 2'b01, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL ldh_wait%0d got=%b exp=0", i, req_o); end
      @(negedge clk_i);
    end
    buffer_empty_i = 1;
    @(negedge clk_i);
    checks++; if (req_o !== 1'b1 || req_addr_o !== 32'h3000 || req_tag_o !== 2'd0) begin failures++; $display("FAIL ldh_req req=%b addr=%h tag=%0d exp 1 00003000 0", req_o, req_addr_o, req_tag_o); end
    @(negedge clk_i);
    respond(2'd0, 32'h8765_4321);
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'h0000_8765) begin failures++; $display("FAIL ldh_data dv=%b data=%h exp 1 00008765", data_valid_o, data_o); end
    retire();
  endtask

  task automatic test_forward;
    load(32'h6000, 2'b10, 0, 1, 1, 32'hDEAD_BEEF);
    checks++; if (data_valid_o !== 1'b1 || data_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fwd_data dv=%b data=%h exp 1 deadbeef", data_valid_o, data_o); end
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL fwd_req got=%b exp=0", req_o); end
    retire();
    checks++; if (req_o !== 1'b0 || idle_o !== 1'b1) begin failures++; $display("FAIL fwd_after req=%b idle=%b exp 0 1", req_o, idle_o); end
  endtask

  task automatic test_reset_mid;
    load(32'h5000, 2'b10, 0, 1, 0, 0);
    checks++; if (req_o !== 1'b1 || req_tag_o !== 2'd2) begin failures++; $display("FAIL mid_req req=%b tag=%0d exp 1 2", req_o, req_tag_o); end
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    checks++; if (idle_o !== 1'b1 || ready_o !== 1'b1 || req_o !== 1'b0) begin failures++; $display("FAIL mid_rst idle=%b ready=%b req=%b exp 1 1 0", idle_o, ready_o, req_o); end
    rst_i = 0;
    respond(2'd2, 32'hBAD0_BAD0);
    checks++; if (data_valid_o !== 1'b0) begin failures++; $display("FAIL mid_stale_rsp got=%b exp=0", data_valid_o); end
    @(negedge clk_i);
    checks++; if (data_valid_o !== 1'b0 || idle_o !== 1'b1) begin failures++; $display("FAIL mid_after dv=%b idle=%b exp 0 1", data_valid_o, idle_o); end
  endtask

  initial begin
    test_reset();
    test_ldb_signed();
    test_misaligned();
    test_illegal();
    test_out_of_order();
    test_ldh_drain();
    test_forward();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
